// File: rtl/game_pkg.sv
// Shared encodings and widths for the game timer: phase states and BCD score geometry.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int SCORE_W = 12;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD score counter with synchronous clear and increment enable.
// The count saturates at 999 instead of wrapping.
module bcd_counter3
  import game_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2
);

  logic [SCORE_W-1:0] score_q;

  function automatic logic [SCORE_W-1:0] bcd_sat_inc(input logic [SCORE_W-1:0] s);
    logic [DIGIT_W-1:0] d0, d1, d2;
    {d2, d1, d0} = s;
    if (d0 != BCD_MAX) begin
      d0 = d0 + DIGIT_W'(1);
    end else if (d1 != BCD_MAX) begin
      d0 = '0;
      d1 = d1 + DIGIT_W'(1);
    end else if (d2 != BCD_MAX) begin
      d0 = '0;
      d1 = '0;
      d2 = d2 + DIGIT_W'(1);
    end
    return {d2, d1, d0};
  endfunction

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      score_q <= '0;
    end else if (clr) begin
      score_q <= '0;
    end else if (inc) begin
      score_q <= bcd_sat_inc(score_q);
    end
  end

  assign {digit2, digit1, digit0} = score_q;

endmodule

// File: rtl/game_timer_ctrl.sv
// Game-phase sequencer: divides CLOCK_50 into score ticks, runs IDLE/RUN/HIT/OVER,
// blinks the display while HIT and latches the best score on entering OVER.
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int BLINK_TICKS = 3
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  input  logic               collided,
  input  logic               clear_req,
  output logic               run,
  output logic               tick,
  output logic [1:0]         state,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic [SCORE_W-1:0] best,
  output logic               blank
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int BLK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

  state_t             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [BLK_W-1:0]   blink_q;
  logic               wrap;
  logic               score_clr;
  logic               score_inc;
  logic [SCORE_W-1:0] score;

  assign wrap      = (div_q == DIV_LAST);
  assign score_clr = clear_req | (start & ((state_q == IDLE) | (state_q == OVER)));
  // A collision on the wrap edge wins over the increment.
  assign score_inc = ~clear_req & (state_q == RUN) & ~collided & wrap;

  bcd_counter3 u_score (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clr      (score_clr),
    .inc      (score_inc),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2)
  );

  assign score = {digit2, digit1, digit0};

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      div_q   <= '0;
      blink_q <= '0;
      tick    <= 1'b0;
      blank   <= 1'b0;
      best    <= '0;
    end else begin
      tick <= 1'b0;
      if (clear_req) begin
        state_q <= IDLE;
        div_q   <= '0;
        blank   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            div_q <= '0;
            if (start) state_q <= RUN;
          end
          RUN: begin
            if (collided) begin
              state_q <= HIT;
              div_q   <= '0;
              blink_q <= '0;
              blank   <= 1'b1;
            end else if (wrap) begin
              div_q <= '0;
              tick  <= 1'b1;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
          HIT: begin
            if (wrap) begin
              div_q   <= '0;
              blank   <= ~blank;
              blink_q <= blink_q + BLK_W'(1);
              if (blink_q == BLK_LAST) begin
                state_q <= OVER;
                blank   <= 1'b0;
                // Packed BCD orders the same as the decimal value.
                if (score > best) best <= score;
              end
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
          OVER: begin
            div_q <= '0;
            if (start) state_q <= RUN;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign state = state_q;
  assign run   = (state_q == RUN);

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl with a cycle-level score/phase reference model.
module tb_game_timer_ctrl;

  localparam int TD = 4;
  localparam int BT = 3;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic        collided = 1'b0;
  logic        clear_req = 1'b0;
  logic        run, tick, blank;
  logic [1:0]  state;
  logic [3:0]  digit0, digit1, digit2;
  logic [11:0] best;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0..3, cycles since last wrap/entry, decimal score and best.
  int m_phase, m_cnt, m_score, m_best, m_wraps;
  bit m_tick, m_blank;

  game_timer_ctrl #(.TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .start     (start),
    .collided  (collided),
    .clear_req (clear_req),
    .run       (run),
    .tick      (tick),
    .state     (state),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .best      (best),
    .blank     (blank)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [28:0] dv;
  assign dv = {state, digit2, digit1, digit0, best, tick, blank, run};

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [28:0] exp_vec();
    return {2'(m_phase), to_bcd(m_score), to_bcd(m_best), m_tick, m_blank, (m_phase == 1)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_score = 0; m_best = 0; m_wraps = 0;
    m_tick = 0; m_blank = 0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit r);
    m_tick = 0;
    if (r) begin
      m_phase = 0; m_score = 0; m_cnt = 0; m_blank = 0;
    end else if (m_phase == 0 || m_phase == 3) begin
      m_cnt = 0;
      if (s) begin m_phase = 1; m_score = 0; end
    end else if (m_phase == 1) begin
      if (c) begin
        m_phase = 2; m_cnt = 0; m_wraps = 0; m_blank = 1;
      end else begin
        m_cnt++;
        if (m_cnt == TD) begin
          m_cnt = 0; m_tick = 1;
          if (m_score < 999) m_score++;
        end
      end
    end else begin
      m_cnt++;
      if (m_cnt == TD) begin
        m_cnt = 0; m_wraps++; m_blank = !m_blank;
        if (m_wraps == BT) begin
          m_phase = 3; m_blank = 0;
          if (m_score > m_best) m_best = m_score;
        end
      end
    end
  endtask

  task automatic cycle(input bit s, input bit c, input bit r);
    start = s; collided = c; clear_req = r;
    @(posedge CLOCK_50);
    model_step(s, c, r);
    #1;
    start = 1'b0; clear_req = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (dv !== 29'd0) begin
      errors++; $display("FAIL reset_state got=%h want=%h", dv, 29'd0);
    end
    @(negedge CLOCK_50) resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (dv !== exp_vec() || state !== 2'd0) begin
        errors++; $display("FAIL idle_after_reset got=%h want=%h", dv, exp_vec());
      end
    end
  endtask

  task automatic test_first_game();
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd1 || run !== 1'b1) begin
      errors++; $display("FAIL enter_run state=%0d run=%b want 1/1", state, run);
    end
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (tick !== ((i % 4) == 0) || dv !== exp_vec()) begin
        errors++; $display("FAIL tick_cadence cyc=%0d tick=%b got=%h want=%h", i, tick, dv, exp_vec());
      end
    end
    checks++;
    if ({digit2, digit1, digit0} !== 12'h010) begin
      errors++; $display("FAIL score_10 got=%h want=010", {digit2, digit1, digit0});
    end
  endtask

  task automatic test_bcd_carry();
    int targets[3] = '{99, 100, 999};
    logic [11:0] want[3] = '{12'h099, 12'h100, 12'h999};
    for (int t = 0; t < 3; t++) begin
      bit hit = 0;
      for (int n = 0; n < 5000 && !hit; n++) begin
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (dv !== exp_vec()) begin
          errors++; $display("FAIL run_to_%0d got=%h want=%h", targets[t], dv, exp_vec());
        end
        if (m_tick && m_score == targets[t]) hit = 1;
      end
      checks++;
      if (!hit || {digit2, digit1, digit0} !== want[t]) begin
        errors++; $display("FAIL carry_%0d reached=%b got=%h want=%h", targets[t], hit,
                           {digit2, digit1, digit0}, want[t]);
      end
    end
    for (int i = 0; i < TD; i++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if ({digit2, digit1, digit0} !== 12'h999 || tick !== 1'b1) begin
      errors++; $display("FAIL saturate got=%h tick=%b want=999 tick=1", {digit2, digit1, digit0}, tick);
    end
  endtask

  task automatic test_hit_blink();
    bit hit = 0;
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 100 && !hit; n++) begin
      if (m_score == 7 && m_cnt == TD - 1) hit = 1;
      else cycle(1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (!hit || {digit2, digit1, digit0} !== 12'h007 || state !== 2'd2 || tick !== 1'b0 || blank !== 1'b1) begin
      errors++; $display("FAIL collide_on_wrap reached=%b got=%h want=%h", hit, dv,
                         {2'd2, 12'h007, 12'h000, 1'b0, 1'b1, 1'b0});
    end
    for (int i = 1; i <= 12; i++) begin
      bit eb = (i < 4) || (i >= 8 && i < 12);
      logic [1:0] es = (i < 12) ? 2'd2 : 2'd3;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (blank !== eb || state !== es || dv !== exp_vec()) begin
        errors++; $display("FAIL hit_blink cyc=%0d blank=%b state=%0d want %b/%0d", i, blank, state, eb, es);
      end
    end
    collided = 1'b0;
    checks++;
    if (best !== 12'h007) begin
      errors++; $display("FAIL best_7 got=%h want=007", best);
    end
  endtask

  task automatic play_game(input int target);
    bit hit = 0;
    cycle(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 200 && !hit; n++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (m_tick && m_score == target) hit = 1;
    end
    repeat ($urandom_range(0, TD - 1)) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 20 && m_phase != 3; n++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (dv !== exp_vec()) begin
        errors++; $display("FAIL game_%0d got=%h want=%h", target, dv, exp_vec());
      end
    end
    collided = 1'b0;
    checks++;
    if (!hit || state !== 2'd3 || {digit2, digit1, digit0} !== to_bcd(target)) begin
      errors++; $display("FAIL over_%0d reached=%b state=%0d score=%h", target, hit, state, {digit2, digit1, digit0});
    end
  endtask

  task automatic test_best();
    play_game(5);
    checks++;
    if (best !== 12'h007) begin
      errors++; $display("FAIL best_keep got=%h want=007", best);
    end
    play_game(12);
    checks++;
    if (best !== 12'h012) begin
      errors++; $display("FAIL best_12 got=%h want=012", best);
    end
  endtask

  task automatic test_clear();
    cycle(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 100 && m_score != 3; n++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if (state !== 2'd0 || {digit2, digit1, digit0} !== 12'h000 || best !== 12'h012 || run !== 1'b0) begin
      errors++; $display("FAIL clear_req got=%h want=%h", dv, {2'd0, 12'h000, 12'h012, 3'b000});
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    #3 resetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dv !== 29'd0) begin
      errors++; $display("FAIL async_reset got=%h want=%h", dv, 29'd0);
    end
    @(negedge CLOCK_50) resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (state !== 2'd0 || dv !== exp_vec()) begin
        errors++; $display("FAIL stay_idle cyc=%0d got=%h want=%h", i, dv, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit c = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) c = !c;
      cycle(1'($urandom_range(0, 7) == 0), c, 1'($urandom_range(0, 63) == 0));
      checks++;
      if (dv !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", i, dv, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_game();
    test_bcd_carry();
    test_hit_blink();
    test_best();
    test_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
